// File: rtl/fir_result_reader_pkg.sv
// Shared FIR package: default widths for result words and RAM addressing,
// plus the state encoding of the result reader FSM.
//   FIR_DATA_W : result word width
//   FIR_ADDR_W : coefficient/result RAM address width
//   FIR_COL_W  : column-mux select width (4:1 mux)
package fir_result_reader_pkg;

    localparam int FIR_DATA_W = 22;
    localparam int FIR_ADDR_W = 8;
    localparam int FIR_COL_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_e;

endpackage

// File: rtl/fir_result_reader_if.sv
// Bus bundle between the result reader, the result RAM and the downstream sink.
//   RAM side   : mem_nce, mem_nwrt, mem_row, mem_col (reader -> RAM), mem_dout (RAM -> reader)
//   Sink side  : m_data, m_valid (reader -> sink), m_ready (sink -> reader)
// master = result reader, slave = RAM model plus sink.
interface fir_result_reader_if
    import fir_result_reader_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int COL_W  = FIR_COL_W
);
    logic                     mem_nce;
    logic                     mem_nwrt;
    logic [ADDR_W-COL_W-1:0]  mem_row;
    logic [COL_W-1:0]         mem_col;
    logic [DATA_W-1:0]        mem_dout;
    logic [DATA_W-1:0]        m_data;
    logic                     m_valid;
    logic                     m_ready;

    modport master (
        output mem_nce, mem_nwrt, mem_row, mem_col, m_data, m_valid,
        input  mem_dout, m_ready
    );

    modport slave (
        input  mem_nce, mem_nwrt, mem_row, mem_col, m_data, m_valid,
        output mem_dout, m_ready
    );

endinterface

// File: rtl/fir_result_reader_skid_fifo.sv
// fir_skid_fifo: 2-entry FIFO that absorbs RAM read data while the sink stalls.
//   clk, rst   : clock, synchronous active-high reset
//   push       : capture push_data this edge (caller guarantees room)
//   push_data  : word to capture
//   pop        : head is consumed this edge (ignored when empty)
//   head_data  : oldest stored word
//   head_valid : FIFO not empty
//   count      : number of stored words, 0..2
module fir_skid_fifo
    import fir_result_reader_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              do_pop;

    assign head_valid = (count_q != 2'd0);
    assign head_data  = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign do_pop     = pop && head_valid;

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two storage words are reset so the head reads zero after
            // reset; this is cheap at depth 2 and keeps m_data deterministic.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fir_result_reader.sv
// fir_result_reader: dumps num_words consecutive words of the result RAM,
// starting at base_addr, to a valid/ready sink in address order.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle dump request, honoured only when idle
//   base_addr  : first RAM address (wraps 255 -> 0)
//   num_words  : words to dump, 0..256
//   busy       : dump in progress
//   done       : one-cycle pulse after the last word is accepted
//   bus        : RAM read port and result stream (fir_result_reader_if.master)
module fir_result_reader
    import fir_result_reader_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int COL_W  = FIR_COL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     num_words,
    output logic                busy,
    output logic                done,
    fir_result_reader_if.master bus
);

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rd_left_q;
    logic [ADDR_W:0]   xfer_left_q;
    logic              rd_pend_q;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [2:0]        occupancy;
    logic              issue;
    logic              accept;
    logic              xfer;

    assign xfer = fifo_valid && bus.m_ready;

    // Words issued but not yet handed to the sink, after this cycle's transfer.
    // Crediting the transfer lets a read go out every cycle while the sink keeps up.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pend_q} - {2'b00, xfer};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d = state_q;
        issue   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                issue = (occupancy < 3'd2);
                if (issue && rd_left_q == CNT_ONE) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && xfer_left_q == CNT_ONE) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rd_left_q   <= '0;
            xfer_left_q <= '0;
            rd_pend_q   <= 1'b0;   // drops any read still in flight
        end else begin
            state_q   <= state_d;
            rd_pend_q <= issue;
            if (accept) begin
                addr_q      <= base_addr;
                rd_left_q   <= num_words;
                xfer_left_q <= num_words;
            end else begin
                if (issue) begin
                    addr_q    <= addr_q + ADDR_ONE;
                    rd_left_q <= rd_left_q - CNT_ONE;
                end
                if (xfer) begin
                    xfer_left_q <= xfer_left_q - CNT_ONE;
                end
            end
        end
    end

    // RAM data is valid the cycle after the enabled edge, so capture on rd_pend_q.
    fir_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (rd_pend_q),
        .push_data  (bus.mem_dout),
        .pop        (bus.m_ready),
        .head_data  (bus.m_data),
        .head_valid (fifo_valid),
        .count      (fifo_count)
    );

    assign bus.m_valid  = fifo_valid;
    assign bus.mem_nce  = ~issue;
    assign bus.mem_nwrt = 1'b1;
    assign bus.mem_row  = addr_q[ADDR_W-1:COL_W];
    assign bus.mem_col  = addr_q[COL_W-1:0];
    assign busy         = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_FINISH);

endmodule
